// File: rtl/mc_cmd_queue_pkg.sv
// Shared widths, defaults and FSM encoding for the CPU-side memory-controller command queue.
// Every block in the queue slice imports this package.
package mc_cmd_queue_pkg;

  localparam int MC_DATA_W = 16;
  localparam int MC_ADDR_W = 4;
  localparam int MC_DEPTH  = 4;
  localparam int MC_RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_RWAIT = 2'd3
  } mc_state_e;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mc_cmd_queue_if.sv
// Request, controller and response signals of the command queue, grouped as one bundle.
// The slave modport is the queue itself; the master modport is the CPU plus controller side.
interface mc_cmd_queue_if
  import mc_cmd_queue_pkg::*;
#(
  parameter int DATA_W = MC_DATA_W,
  parameter int ADDR_W = MC_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              CPU_RD;
  logic              CPU_WR;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic [DATA_W-1:0] mc_rdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;

  logic              busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mc_rdata,
    output req_ready, CPU_RD, CPU_WR, mc_addr, mc_wdata,
           rsp_valid, rsp_rdata, rsp_addr, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mc_rdata,
    input  req_ready, CPU_RD, CPU_WR, mc_addr, mc_wdata,
           rsp_valid, rsp_rdata, rsp_addr, busy
  );

endinterface

// File: rtl/mc_cmd_fifo.sv
// In-order command FIFO with a registered occupancy count; pointers wrap modulo DEPTH.
// Storage is not reset: only the pointers and count define which entries are live.
module mc_cmd_fifo
  import mc_cmd_queue_pkg::*;
#(
  parameter int WIDTH = 1 + MC_ADDR_W + MC_DATA_W,
  parameter int DEPTH = MC_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [cnt_width(DEPTH)-1:0]    count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // A push and a pop on the same edge leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mc_cmd_queue.sv
// CPU-side command front end: queues read/write requests and issues them one at a time as
// single-cycle CPU_RD/CPU_WR strobes, returning read data RD_LAT edges after each read strobe.
module mc_cmd_queue
  import mc_cmd_queue_pkg::*;
#(
  parameter int DATA_W = MC_DATA_W,
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DEPTH  = MC_DEPTH,
  parameter int RD_LAT = MC_RD_LAT
) (
  input logic           clk,
  input logic           rst,
  mc_cmd_queue_if.slave bus
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int LAT_W   = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  mc_state_e state, state_n;

  logic [LAT_W-1:0]  lat_cnt, lat_n;
  logic              cpu_rd_q, cpu_rd_n;
  logic              cpu_wr_q, cpu_wr_n;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_n;
  logic [DATA_W-1:0] mc_wdata_q, mc_wdata_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_n;

  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               head_we;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  assign fifo_push  = bus.req_valid & bus.req_ready;
  assign fifo_din   = {bus.req_we, bus.req_addr, bus.req_wdata};
  assign head_we    = fifo_dout[ENTRY_W-1];
  assign head_addr  = fifo_dout[DATA_W +: ADDR_W];
  assign head_wdata = fifo_dout[DATA_W-1:0];

  mc_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign bus.req_ready = ~fifo_full;
  assign bus.busy      = (fifo_count != '0) || (state != ST_IDLE);

  assign bus.CPU_RD    = cpu_rd_q;
  assign bus.CPU_WR    = cpu_wr_q;
  assign bus.mc_addr   = mc_addr_q;
  assign bus.mc_wdata  = mc_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_addr  = rsp_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      cpu_rd_q    <= 1'b0;
      cpu_wr_q    <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state       <= state_n;
      lat_cnt     <= lat_n;
      cpu_rd_q    <= cpu_rd_n;
      cpu_wr_q    <= cpu_wr_n;
      mc_addr_q   <= mc_addr_n;
      mc_wdata_q  <= mc_wdata_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_addr_q  <= rsp_addr_n;
    end
  end

  // lat_cnt counts edges since the read strobe rose; the capture edge is where it reaches RD_LAT-1.
  always_comb begin
    state_n     = state;
    lat_n       = lat_cnt;
    cpu_rd_n    = 1'b0;
    cpu_wr_n    = 1'b0;
    mc_addr_n   = mc_addr_q;
    mc_wdata_n  = mc_wdata_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_addr_n  = rsp_addr_q;
    fifo_pop    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mc_addr_n  = head_addr;
          mc_wdata_n = head_wdata;
          if (head_we) begin
            cpu_wr_n = 1'b1;
            state_n  = ST_WR;
          end else begin
            cpu_rd_n = 1'b1;
            lat_n    = '0;
            state_n  = ST_RD;
          end
        end
      end

      ST_WR: begin
        state_n = ST_IDLE;
      end

      ST_RD: begin
        if (RD_LAT == 1) begin
          rsp_valid_n = 1'b1;
          rsp_rdata_n = bus.mc_rdata;
          rsp_addr_n  = mc_addr_q;
          state_n     = ST_IDLE;
        end else begin
          lat_n   = lat_cnt + LAT_W'(1);
          state_n = ST_RWAIT;
        end
      end

      ST_RWAIT: begin
        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
          rsp_valid_n = 1'b1;
          rsp_rdata_n = bus.mc_rdata;
          rsp_addr_n  = mc_addr_q;
          state_n     = ST_IDLE;
        end else begin
          lat_n = lat_cnt + LAT_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_cmd_queue.sv
// Self-checking bench for mc_cmd_queue: directed vector table, hand-written corner sequences and
// randomized traffic against a queue/array reference model plus a behavioural controller memory.
module tb_mc_cmd_queue;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } rsp_t;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  mc_cmd_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mc_cmd_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl_mem [16];
  logic [15:0] ref_mem  [16];
  cmd_t        exp_cmd  [$];
  rsp_t        exp_rsp  [$];
  int          strobe_log [$];

  int          cyc = 0;
  int          ref_count = 0;
  int          last_strobe_cyc = -100;
  int          rd_issue_cyc = 0;
  bit          outstanding = 1'b0;
  bit          prev_push = 1'b0;
  cmd_t        pend;
  logic [15:0] last_rsp_data = '0;
  int          stall_cycles = 0;

  int          rd_age = -1;
  logic [3:0]  rd_addr = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller model: accepts write strobes and presents read data only in the capture window.
  always @(negedge clk) begin
    if (rst) begin
      rd_age = -1;
    end else begin
      if (bus.CPU_WR) ctrl_mem[bus.mc_addr] = bus.mc_wdata;
      if (bus.CPU_RD) begin
        rd_age  = 0;
        rd_addr = bus.mc_addr;
      end else if (rd_age >= 0) begin
        rd_age++;
        if (rd_age > RD_LAT) rd_age = -1;
      end
    end
    bus.mc_rdata = (rd_age == RD_LAT - 1) ? ctrl_mem[rd_addr] : 16'hDEAD;
  end

  // Reference model: program-order queue of commands and expected read results.
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    bit   issued_now;
    if (rst) begin
      exp_cmd.delete();
      exp_rsp.delete();
      ref_count       = 0;
      prev_push       = 1'b0;
      outstanding     = 1'b0;
      last_strobe_cyc = -100;
      for (int i = 0; i < 16; i++) ref_mem[i] = ctrl_mem[i];
    end else begin
      cyc++;
      issued_now = 1'b0;
      if (bus.CPU_WR || bus.CPU_RD) begin
        check_output("single_strobe", {31'b0, bus.CPU_WR & bus.CPU_RD}, 32'd0);
        check_output("strobe_spacing", {31'b0, (cyc - last_strobe_cyc) >= 2}, 32'd1);
        last_strobe_cyc = cyc;
        strobe_log.push_back(bus.CPU_WR ? 1 : 2);
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: got strobe with empty model queue (t=%0t)", $time);
        end else begin
          c = exp_cmd.pop_front();
          ref_count--;
          issued_now = 1'b1;
          check_output("strobe_kind", {31'b0, bus.CPU_WR}, {31'b0, c.we});
          check_output("strobe_addr", {28'b0, bus.mc_addr}, {28'b0, c.addr});
          if (c.we) check_output("strobe_wdata", {16'b0, bus.mc_wdata}, {16'b0, c.data});
          else begin
            outstanding  = 1'b1;
            rd_issue_cyc = cyc;
          end
        end
      end
      if (bus.rsp_valid) begin
        if (!outstanding || exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid with no read outstanding (t=%0t)", $time);
        end else begin
          r = exp_rsp.pop_front();
          check_output("rsp_latency", cyc - rd_issue_cyc, RD_LAT);
          check_output("rsp_addr", {28'b0, bus.rsp_addr}, {28'b0, r.addr});
          check_output("rsp_rdata", {16'b0, bus.rsp_rdata}, {16'b0, r.data});
          last_rsp_data = bus.rsp_rdata;
          outstanding   = 1'b0;
        end
      end else if (outstanding && (cyc - rd_issue_cyc) > RD_LAT) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_rsp: got no rsp_valid, expected one %0d edges after CPU_RD", RD_LAT);
        outstanding = 1'b0;
        if (exp_rsp.size() > 0) void'(exp_rsp.pop_front());
      end
      if (prev_push) begin
        exp_cmd.push_back(pend);
        ref_count++;
        if (pend.we) ref_mem[pend.addr] = pend.data;
        else begin
          r.addr = pend.addr;
          r.data = ref_mem[pend.addr];
          exp_rsp.push_back(r);
        end
      end
      check_output("req_ready", {31'b0, bus.req_ready}, {31'b0, ref_count < DEPTH});
      check_output("busy", {31'b0, bus.busy}, {31'b0, (ref_count > 0) || issued_now || outstanding});
      prev_push = bus.req_valid && bus.req_ready;
      pend.we   = bus.req_we;
      pend.addr = bus.req_addr;
      pend.data = bus.req_wdata;
    end
  end

  task automatic push_req(input bit we, input logic [3:0] a, input logic [15:0] d);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      stall_cycles++;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL push_timeout: got req_ready=0 for 200 cycles, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy=%b after 300 cycles, expected 0", bus.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cpu_rd"}, {31'b0, bus.CPU_RD}, 32'd0);
    check_output({tag, "_cpu_wr"}, {31'b0, bus.CPU_WR}, 32'd0);
    check_output({tag, "_mc_addr"}, {28'b0, bus.mc_addr}, 32'd0);
    check_output({tag, "_mc_wdata"}, {16'b0, bus.mc_wdata}, 32'd0);
    check_output({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    check_output({tag, "_rsp_rdata"}, {16'b0, bus.rsp_rdata}, 32'd0);
    check_output({tag, "_rsp_addr"}, {28'b0, bus.rsp_addr}, 32'd0);
    check_output({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check_output({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
  endtask

  // One request into an empty, idle queue, checked edge by edge against the table entry.
  task automatic apply_stimulus(input vec_t v);
    bit exp_rsp_now;
    wait_idle();
    push_req(v.we, v.addr, v.wdata);
    for (int k = 0; k <= RD_LAT + 2; k++) begin
      @(negedge clk);
      exp_rsp_now = !v.we && (k == 1 + RD_LAT);
      check_output("vec_cpu_wr", {31'b0, bus.CPU_WR}, {31'b0, (k == 1) && v.we});
      check_output("vec_cpu_rd", {31'b0, bus.CPU_RD}, {31'b0, (k == 1) && !v.we});
      if (k == 1) begin
        check_output("vec_mc_addr", {28'b0, bus.mc_addr}, {28'b0, v.addr});
        if (v.we) check_output("vec_mc_wdata", {16'b0, bus.mc_wdata}, {16'b0, v.wdata});
      end
      check_output("vec_rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_rsp_now});
      if (exp_rsp_now) begin
        check_output("vec_rsp_rdata", {16'b0, bus.rsp_rdata}, {16'b0, v.exp_rdata});
        check_output("vec_rsp_addr", {28'b0, bus.rsp_addr}, {28'b0, v.addr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vectors [8];
    int   n_guard;

    for (int i = 0; i < 16; i++) ctrl_mem[i] = 16'h1111 * i[15:0];
    ctrl_mem[5] = 16'h1234;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    vectors[0] = '{we: 1'b1, addr: 4'h3, wdata: 16'hBEEF, exp_rdata: 16'h0000};
    vectors[1] = '{we: 1'b0, addr: 4'h5, wdata: 16'h0000, exp_rdata: 16'h1234};
    vectors[2] = '{we: 1'b0, addr: 4'h3, wdata: 16'h0000, exp_rdata: 16'hBEEF};
    vectors[3] = '{we: 1'b1, addr: 4'h5, wdata: 16'h0A5A, exp_rdata: 16'h0000};
    vectors[4] = '{we: 1'b0, addr: 4'h5, wdata: 16'hFFFF, exp_rdata: 16'h0A5A};
    vectors[5] = '{we: 1'b0, addr: 4'h9, wdata: 16'h0000, exp_rdata: 16'h9999};
    vectors[6] = '{we: 1'b1, addr: 4'hF, wdata: 16'h0001, exp_rdata: 16'h0000};
    vectors[7] = '{we: 1'b0, addr: 4'hF, wdata: 16'h0000, exp_rdata: 16'h0001};

    for (int i = 0; i < 8; i++) apply_stimulus(vectors[i]);

    // Fill: back-to-back reads outrun the issue rate, so the queue must fill and stall pushes.
    wait_idle();
    stall_cycles = 0;
    for (int i = 0; i < 8; i++) push_req(1'b0, i[3:0], 16'h0000);
    check_output("fill_stalled", {31'b0, stall_cycles > 0}, 32'd1);
    wait_idle();

    // Ordering: write, read, write to one address.
    strobe_log.delete();
    push_req(1'b1, 4'hA, 16'h00AA);
    push_req(1'b0, 4'hA, 16'h0000);
    push_req(1'b1, 4'hA, 16'h00BB);
    wait_idle();
    check_output("order_count", strobe_log.size(), 3);
    if (strobe_log.size() == 3) begin
      check_output("order_0", strobe_log[0], 1);
      check_output("order_1", strobe_log[1], 2);
      check_output("order_2", strobe_log[2], 1);
    end
    check_output("order_rdata", {16'b0, last_rsp_data}, 32'h00AA);
    check_output("order_final_mem", {16'b0, ctrl_mem[10]}, 32'h00BB);

    // Reset while waiting for read data.
    push_req(1'b0, 4'h7, 16'h0000);
    n_guard = 0;
    @(negedge clk);
    while (bus.CPU_RD !== 1'b1 && n_guard < 20) begin
      @(negedge clk);
      n_guard++;
    end
    check_output("rst_mid_read_strobe_seen", {31'b0, bus.CPU_RD}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_read");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output("rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic: dense enough to hit full, simultaneous push/pop and pointer wrap.
    for (int n = 0; n < 48; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      push_req(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
    end
    wait_idle();
    check_output("rand_cmd_drained", exp_cmd.size(), 0);
    check_output("rand_rsp_drained", exp_rsp.size(), 0);
    for (int i = 0; i < 16; i++) check_output("rand_mem", {16'b0, ctrl_mem[i]}, {16'b0, ref_mem[i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
